// File: rtl/pci_seq_pkg.sv
// Shared definitions for the BAR0 command sequencer: register indices,
// CTRL/STATUS bit positions and the FSM state encoding.
package pci_seq_pkg;

    localparam logic [1:0] REG_CMD     = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_DONECNT = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_FLUSH     = 2;
    localparam int CTRL_DRAIN_CLR = 3;

    localparam int STAT_EMPTY   = 4;
    localparam int STAT_FULL    = 5;
    localparam int STAT_STATE   = 6;
    localparam int STAT_OVF     = 8;
    localparam int STAT_DRAINED = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RUN   = 2'b10
    } seq_state_e;

endpackage

// File: rtl/seq_fifo.sv
// Small synchronous FIFO holding queued command words. The head word is
// presented combinationally so the owner can capture it on the pop edge.
module seq_fifo
    import pci_seq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = level_q[DEPTH_LOG2];
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves on the same edge.
    assign pop_ok  = pop && !flush && !empty;
    assign push_ok = push && !flush && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            level_d = level_q + LW'(push_ok) - LW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/pci_cmd_sequencer.sv
// BAR0 command sequencer: queues host command words and issues them one at a
// time to the step generator, with CTRL/STATUS/DONECNT readback and drain IRQ.
module pci_cmd_sequencer
    import pci_seq_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int CNT_W      = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_STB,
    input  logic [1:0]  WR_ADDR,
    input  logic [31:0] WR_DATA,
    input  logic [3:0]  WR_BE_N,
    input  logic [1:0]  RD_ADDR,
    output logic [31:0] RD_DATA,
    output logic [31:0] CMD_DATA,
    output logic        CMD_VALID,
    input  logic        CMD_READY,
    input  logic        CMD_DONE,
    output logic        BUSY,
    output logic        IRQ
);

    seq_state_e       state_q, state_d;
    logic [31:0]      cmd_data_q, cmd_data_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             en_q, en_d;
    logic             irq_en_q, irq_en_d;
    logic             ovf_q, ovf_d;
    logic             drained_q, drained_d;
    logic [CNT_W-1:0] donecnt_q, donecnt_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [31:0]         fifo_head;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                fifo_empty, fifo_full;

    logic        cmd_push, ctrl_wr, flush, drain_clr, ovf_clr;
    logic        fifo_pop, push_acc, done_ev;
    logic [31:0] ctrl_word, status_word;
    logic        unused_be;

    assign unused_be = ^WR_BE_N[3:1];

    assign cmd_push  = WR_STB && (WR_ADDR == REG_CMD);
    assign ctrl_wr   = WR_STB && (WR_ADDR == REG_CTRL) && !WR_BE_N[0];
    assign flush     = ctrl_wr && WR_DATA[CTRL_FLUSH];
    assign drain_clr = ctrl_wr && WR_DATA[CTRL_DRAIN_CLR];
    assign ovf_clr   = WR_STB && (WR_ADDR == REG_STATUS) && WR_DATA[STAT_OVF];

    // Flush wins over a pop so a flushed head never reaches CMD_DATA.
    assign fifo_pop = (state_q == S_IDLE) && en_q && !fifo_empty && !flush;
    assign push_acc = cmd_push && !flush && (!fifo_full || fifo_pop);
    assign done_ev  = (state_q == S_RUN) && CMD_DONE;

    seq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (32)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (cmd_push),
        .pop     (fifo_pop),
        .flush   (flush),
        .wr_data (WR_DATA),
        .rd_data (fifo_head),
        .level   (fifo_level),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[CTRL_EN]     = en_q;
        ctrl_word[CTRL_IRQ_EN] = irq_en_q;

        status_word                      = '0;
        status_word[DEPTH_LOG2:0]        = fifo_level;
        status_word[STAT_EMPTY]          = fifo_empty;
        status_word[STAT_FULL]           = fifo_full;
        status_word[STAT_STATE +: 2]     = state_q;
        status_word[STAT_OVF]            = ovf_q;
        status_word[STAT_DRAINED]        = drained_q;
    end

    always_comb begin
        state_d    = state_q;
        cmd_data_d = cmd_data_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        ovf_d      = ovf_q;
        drained_d  = drained_q;
        donecnt_d  = donecnt_q;
        rd_data_d  = '0;

        if (ctrl_wr) begin
            en_d     = WR_DATA[CTRL_EN];
            irq_en_d = WR_DATA[CTRL_IRQ_EN];
        end

        case (state_q)
            S_IDLE: begin
                if (fifo_pop) begin
                    state_d    = S_ISSUE;
                    cmd_data_d = fifo_head;
                end
            end
            S_ISSUE: begin
                if (flush)          state_d = S_IDLE;
                else if (CMD_READY) state_d = S_RUN;
            end
            S_RUN: begin
                if (CMD_DONE) begin
                    state_d   = S_IDLE;
                    donecnt_d = donecnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        cmd_valid_d = (state_d == S_ISSUE);

        if (cmd_push && !flush && fifo_full && !fifo_pop) ovf_d = 1'b1;
        else if (ovf_clr)                                  ovf_d = 1'b0;

        // A drain event on the same edge as a clear leaves DRAINED set.
        if (done_ev && fifo_empty)       drained_d = 1'b1;
        else if (drain_clr || push_acc)  drained_d = 1'b0;

        case (RD_ADDR)
            REG_CTRL:    rd_data_d = ctrl_word;
            REG_STATUS:  rd_data_d = status_word;
            REG_DONECNT: rd_data_d = 32'(donecnt_q);
            default:     rd_data_d = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            ovf_q       <= 1'b0;
            drained_q   <= 1'b0;
            donecnt_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            ovf_q       <= ovf_d;
            drained_q   <= drained_d;
            donecnt_q   <= donecnt_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign CMD_DATA  = cmd_data_q;
    assign CMD_VALID = cmd_valid_q;
    assign RD_DATA   = rd_data_q;
    assign BUSY      = (state_q != S_IDLE) || !fifo_empty;
    assign IRQ       = irq_en_q && drained_q;

endmodule
